uart_rx: RTL and testbench

Receive half of the team's UART. It takes the asynchronous serial line driven by the `uart` transmitter, or by an external device, and recovers 8N1 frames. Each byte is validated on its start and stop bits and delivered through a one-entry holding register with a valid/ready handshake. It sits beside `uart` in the top level and uses the same `clk` domain and bit-period convention.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM and a
// one-entry holding register with valid/ready handoff.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s to fall
// S_START | timing to mid start bit, re-checking for a glitch
// S_DATA  | sampling 8 data bits, LSB first, one per bit period
// S_STOP  | sampling the stop bit, delivering or flagging the byte
// S_WAIT  | bad stop bit seen, holding until the line returns high
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_t;

   state_t        state_q;
   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          busy_q;
   logic          ferr_q;
   logic          ovr_q;
   logic          rx_s;

   assign rx_s = sync2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= rx_in;
         sync2_q <= sync1_q;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         // Plain consumption; a delivery in S_STOP below overrides it.
         if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     idx_q   <= '0;
                     state_q <= S_DATA;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                     if (!valid_q || rx_ready) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= S_WAIT;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_WAIT: begin
               // A held-low line (break) must not be decoded as new frames.
               if (rx_s) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign rx_busy   = busy_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected bytes/pulses, a
// monitor on the falling clock edge pops and compares whatever the DUT presents.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int K_BYTE = 0;
   localparam int K_FERR = 1;
   localparam int K_OVR  = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   ev_t  exp_q[$];
   int   checks;
   int   errors;
   int   cyc;
   int   last_load_cyc;
   int   fall_cyc;
   int   lat;
   logic pv, pr, pfe, pov;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic sb_check(input int kind, input logic [7:0] data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual kind=%0d data=%0h required none", kind, data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.data !== data) begin
            errors++;
            $display("FAIL scoreboard actual kind=%0d data=%0h required kind=%0d data=%0h",
                     kind, data, e.kind, e.data);
         end
      end
   endtask

   task automatic push(input int kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic clocks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bit_out(input logic v);
      rx_in = v;
      clocks(CPB);
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      bit_out(stop);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      last_load_cyc = 0;
      pv = 1'b0; pr = 1'b0; pfe = 1'b0; pov = 1'b0;
      rst = 1'b0;
      rx_in = 1'b1;
      rx_ready = 1'b1;

      fork
         forever begin
            @(negedge clk);
            cyc++;
            if (rx_valid && (!pv || pr)) begin
               last_load_cyc = cyc;
               sb_check(K_BYTE, rx_data);
            end
            if (frame_err) begin
               sb_check(K_FERR, 8'h00);
               chk("frame_err_width", {31'd0, pfe}, 32'd0);
            end
            if (overrun) begin
               sb_check(K_OVR, 8'h00);
               chk("overrun_width", {31'd0, pov}, 32'd0);
            end
            pv = rx_valid; pr = rx_ready; pfe = frame_err; pov = overrun;
         end
      join_none

      // Reset values
      clocks(3);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_data", {24'd0, rx_data}, 32'h00);
      chk("rst_busy", {31'd0, rx_busy}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      rst = 1'b1;
      clocks(5);

      // Single byte
      push(K_BYTE, 8'hDB);
      fall_cyc = cyc;
      fork
         send(8'b11011011, 1'b1);
         begin
            clocks(80);
            chk("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
         end
      join
      lat = last_load_cyc - fall_cyc - 1;
      chk("latency_in_range", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
      chk("single_valid_consumed", {31'd0, rx_valid}, 32'd0);
      chk("single_busy_done", {31'd0, rx_busy}, 32'd0);
      clocks(20);

      // Glitch
      rx_in = 1'b0;
      clocks(4);
      rx_in = 1'b1;
      clocks(1);
      chk("glitch_busy_pulse", {31'd0, rx_busy}, 32'd1);
      clocks(20);
      chk("glitch_busy_idle", {31'd0, rx_busy}, 32'd0);
      chk("glitch_no_valid", {31'd0, rx_valid}, 32'd0);

      // Bad stop bit, then line held low two more bits
      push(K_FERR, 8'h00);
      send(8'hA5, 1'b0);
      chk("ferr_busy_held", {31'd0, rx_busy}, 32'd1);
      chk("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
      clocks(2 * CPB);
      chk("ferr_busy_break", {31'd0, rx_busy}, 32'd1);
      rx_in = 1'b1;
      clocks(6);
      chk("ferr_busy_release", {31'd0, rx_busy}, 32'd0);
      clocks(10);
      push(K_BYTE, 8'h5A);
      send(8'h5A, 1'b1);
      clocks(10);

      // Overrun: back-to-back frames with no consumer
      rx_ready = 1'b0;
      push(K_BYTE, 8'h3C);
      send(8'h3C, 1'b1);
      push(K_OVR, 8'h00);
      send(8'hC3, 1'b1);
      chk("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
      chk("ovr_valid_kept", {31'd0, rx_valid}, 32'd1);
      rx_ready = 1'b1;
      clocks(1);
      rx_ready = 1'b0;
      chk("ovr_valid_dropped", {31'd0, rx_valid}, 32'd0);
      clocks(10);

      // Simultaneous load and consume on the stop-sample edge
      push(K_BYTE, 8'h11);
      send(8'h11, 1'b1);
      push(K_BYTE, 8'h22);
      fork
         send(8'h22, 1'b1);
         begin
            clocks(154);
            rx_ready = 1'b1;
            clocks(1);
            rx_ready = 1'b0;
         end
      join
      chk("simul_data", {24'd0, rx_data}, 32'h22);
      chk("simul_valid", {31'd0, rx_valid}, 32'd1);
      rx_ready = 1'b1;
      clocks(10);

      // Reset during data bit 4 of 8'hFF
      rx_in = 1'b0;
      clocks(CPB);
      rx_in = 1'b1;
      clocks(4 * CPB + 8);
      chk("rstmid_busy_before", {31'd0, rx_busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rstmid_busy", {31'd0, rx_busy}, 32'd0);
      chk("rstmid_valid", {31'd0, rx_valid}, 32'd0);
      chk("rstmid_data", {24'd0, rx_data}, 32'h00);
      chk("rstmid_ferr", {31'd0, frame_err}, 32'd0);
      chk("rstmid_ovr", {31'd0, overrun}, 32'd0);
      @(posedge clk);
      clocks(3);
      rst = 1'b1;
      clocks(100);
      chk("rstmid_idle", {31'd0, rx_busy}, 32'd0);
      push(K_BYTE, 8'h55);
      send(8'h55, 1'b1);
      clocks(10);
      chk("last_data", {24'd0, rx_data}, 32'h55);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) clocks(1);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
